// File: rtl/tone_pkg.sv
// Shared types and constants for the tone decoder: FSM states, counter
// width, the eight note half-period centers and the seven-segment table.
package tone_pkg;

  localparam int CNT_W = 13;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Half-period center in clocks for note index 1..8 (C3 .. C4).
  function automatic logic [CNT_W-1:0] note_center(input logic [3:0] idx);
    logic [CNT_W-1:0] c;
    c = '0;
    case (idx)
      4'd1: c = 13'd1911;
      4'd2: c = 13'd1704;
      4'd3: c = 13'd1518;
      4'd4: c = 13'd1433;
      4'd5: c = 13'd1277;
      4'd6: c = 13'd1137;
      4'd7: c = 13'd1013;
      4'd8: c = 13'd957;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Seven-segment pattern, bit order {s1..s7}; index 0 (no note) is blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] idx);
    logic [6:0] p;
    p = 7'b0000000;
    case (idx)
      4'd1: p = 7'b0110000;
      4'd2: p = 7'b1101101;
      4'd3: p = 7'b1111001;
      4'd4: p = 7'b0110011;
      4'd5: p = 7'b1011011;
      4'd6: p = 7'b1011111;
      4'd7: p = 7'b1110000;
      4'd8: p = 7'b1111111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Brings the asynchronous tone input into the clk domain and flags either
// edge. The flag is combinational off the last two flops, so the decoder
// acts on it at the third clk edge after tone_in changes.
module tone_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic tone_in,
  output logic edge_pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Two-flop synchronizer followed by one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= tone_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign edge_pulse = sync2_reg ^ prev_reg;

endmodule

// File: rtl/tone_decoder.sv
// Piezo tone decoder: measures the time between tone edges, classifies it
// against eight note half-periods and locks a note after CONFIRM_CNT
// consecutive matches. Optional macro TONE_PERIOD_OUT_EN adds a
// half_period output carrying the last classified measurement.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CONFIRM_CNT = 4,
  parameter int TOL         = 16,
  parameter int TIMEOUT     = 4095
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tone_in,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic [6:0]       seg
`ifdef TONE_PERIOD_OUT_EN
  ,
  output logic [CNT_W-1:0] half_period
`endif
);

  localparam int MW = $clog2(CONFIRM_CNT + 1);
  localparam logic [MW-1:0]    CONFIRM_W = MW'(CONFIRM_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_W     = (CNT_W + 1)'(TOL);

  logic             edge_pulse;
  logic [CNT_W-1:0] p_reg;
  logic [CNT_W-1:0] meas;
  logic             timeout;
  logic [7:0]       hit;
  logic [3:0]       class_idx;
  logic [3:0]       class_eff;

  state_t           state_reg, state_next;
  logic [3:0]       cand_reg, cand_next;
  logic [MW-1:0]    match_reg, match_next;
  logic [3:0]       note_reg, note_next;
  logic [6:0]       seg_reg, seg_next;

  tone_edge_sync u_sync (
    .clk        (clk),
    .resetn     (resetn),
    .tone_in    (tone_in),
    .edge_pulse (edge_pulse)
  );

  // Gap counter: cleared by each edge, saturates at TIMEOUT during silence.
  always_ff @(posedge clk) begin
    if (!resetn)
      p_reg <= '0;
    else if (edge_pulse)
      p_reg <= '0;
    else if (p_reg != TIMEOUT_W)
      p_reg <= p_reg + CNT_W'(1);
  end

  // P holds clocks elapsed after the clearing edge, so the edge-to-edge gap
  // including the current clock is P + 1.
  assign meas    = p_reg + CNT_W'(1);
  assign timeout = (p_reg == TIMEOUT_W);

  // One window comparator per note; bit gi flags a match to note gi+1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_win
      localparam logic [CNT_W:0] CENTER = {1'b0, note_center(4'(gi + 1))};
      assign hit[gi] = ({1'b0, meas} + TOL_W >= CENTER) &&
                       ({1'b0, meas} <= CENTER + TOL_W);
    end
  endgenerate

  // Priority encode the window hits; the lowest note index wins.
  always_comb begin
    class_idx = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit[i]) class_idx = 4'(i + 1);
    end
  end

  // An edge coinciding with the timeout carries a meaningless gap.
  assign class_eff = timeout ? 4'd0 : class_idx;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= SILENT;
      cand_reg  <= '0;
      match_reg <= '0;
      note_reg  <= '0;
      seg_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      match_reg <= match_next;
      note_reg  <= note_next;
      seg_reg   <= seg_next;
    end
  end

  // Next-state logic: edges first, then timeout, then a pending lock.
  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    match_next = match_reg;
    note_next  = note_reg;
    seg_next   = seg_reg;
    if (edge_pulse) begin
      case (state_reg)
        SILENT: begin
          state_next = ACQUIRE;
          cand_next  = '0;
          match_next = '0;
        end
        ACQUIRE: begin
          // A lock confirmed on the previous clock is committed even if an
          // edge arrives right now, so the confirmation is never lost.
          if (match_reg == CONFIRM_W) begin
            note_next = cand_reg;
            seg_next  = seg_pattern(cand_reg);
          end
          if (match_reg == CONFIRM_W && class_eff == cand_reg) begin
            state_next = LOCKED;
          end else if (class_eff == cand_reg && class_eff != 4'd0) begin
            match_next = match_reg + MW'(1);
          end else begin
            cand_next  = class_eff;
            match_next = (class_eff != 4'd0) ? MW'(1) : '0;
          end
        end
        LOCKED: begin
          if (class_eff != note_reg) begin
            state_next = ACQUIRE;
            cand_next  = class_eff;
            match_next = (class_eff != 4'd0) ? MW'(1) : '0;
          end
        end
        default: state_next = SILENT;
      endcase
    end else if (timeout) begin
      state_next = SILENT;
      cand_next  = '0;
      match_next = '0;
      note_next  = '0;
      seg_next   = '0;
    end else if (state_reg == ACQUIRE && match_reg == CONFIRM_W) begin
      state_next = LOCKED;
      note_next  = cand_reg;
      seg_next   = seg_pattern(cand_reg);
    end
  end

`ifdef TONE_PERIOD_OUT_EN
  logic [CNT_W-1:0] half_period_reg;

  // Capture the measured gap on every classified edge.
  always_ff @(posedge clk) begin
    if (!resetn)
      half_period_reg <= '0;
    else if (edge_pulse && state_reg != SILENT)
      half_period_reg <= meas;
  end

  assign half_period = half_period_reg;
`endif

  assign note       = note_reg;
  assign seg        = seg_reg;
  assign note_valid = (note_reg != 4'd0);

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: reset, lock timing, note change,
// tolerance edges, silence timeout and reset during lock.
module tb_tone_decoder;
  import tone_pkg::*;

  logic       clk;
  logic       resetn;
  logic       tone_in;
  logic [3:0] note;
  logic       note_valid;
  logic [6:0] seg;
`ifdef TONE_PERIOD_OUT_EN
  logic [CNT_W-1:0] half_period;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  tone_decoder dut (
    .clk        (clk),
    .resetn     (resetn),
    .tone_in    (tone_in),
    .note       (note),
    .note_valid (note_valid),
    .seg        (seg)
`ifdef TONE_PERIOD_OUT_EN
    ,
    .half_period(half_period)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_note"},  32'(note),       32'd0);
    check({tag, "_valid"}, 32'(note_valid), 32'd0);
    check({tag, "_seg"},   32'(seg),        32'd0);
  endtask

  // Wait h clocks (sampling on falling edges), then flip the tone.
  task automatic edge_after(input int h);
    repeat (h) @(negedge clk);
    tone_in = ~tone_in;
  endtask

  // Four edges spaced h clocks apart (plus an unclassified starter edge when
  // first is set); the note must hold 'prior' until exactly 4 clocks after
  // the final toggle (3 clocks of sync/edge latency plus one to load).
  task automatic lock_run(input int h, input logic [3:0] want, input logic [6:0] want_seg,
                          input logic [3:0] prior, input bit first);
    if (first) edge_after(20);
    for (int i = 0; i < 4; i++) begin
      edge_after((first && i == 0) ? h : h - 4);
      repeat (3) @(negedge clk);
`ifdef TONE_PERIOD_OUT_EN
      check("half_period", 32'(half_period), 32'(h));
`endif
      check("pre_lock_note", 32'(note), 32'(prior));
      @(negedge clk);
      if (i == 3) begin
        check("lock_note",  32'(note),       32'(want));
        check("lock_seg",   32'(seg),        32'(want_seg));
        check("lock_valid", 32'(note_valid), 32'd1);
      end else begin
        check("no_early_lock", 32'(note), 32'(prior));
      end
    end
  endtask

  initial begin
    resetn  = 1'b0;
    tone_in = 1'b0;

    // Reset held with the tone toggling: outputs stay clear.
    for (int i = 0; i < 5; i++) begin
      tone_in = ~tone_in;
      @(negedge clk);
      check_clear("reset");
    end
    tone_in = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_clear("idle");

    // Lock on C3, then change to C4 while locked.
    lock_run(1911, 4'd1, 7'b0110000, 4'd0, 1'b1);
    lock_run(957,  4'd8, 7'b1111111, 4'd1, 1'b0);

    // Silence: outputs clear 4099 clocks after the last toggle.
    repeat (4094) @(negedge clk);
    check("pre_timeout_note", 32'(note), 32'd8);
    @(negedge clk);
    check_clear("timeout");

    // Tolerance: 1277+16 locks note 5.
    lock_run(1293, 4'd5, 7'b1011011, 4'd0, 1'b1);
    repeat (4096) @(negedge clk);
    check_clear("timeout2");

    // Tolerance: 1277+17 never locks.
    edge_after(20);
    for (int i = 0; i < 6; i++) begin
      edge_after(1294);
      check("out_of_tol_note", 32'(note), 32'd0);
    end
    repeat (5) @(negedge clk);
    check_clear("out_of_tol");

    // F note.
    lock_run(1433, 4'd4, 7'b0110011, 4'd0, 1'b1);

    // Reset while locked clears on the next clock; relock needs 5 edges.
    resetn  = 1'b0;
    tone_in = 1'b0;
    @(negedge clk);
    check_clear("midlock_reset");
`ifdef TONE_PERIOD_OUT_EN
    check("reset_half_period", 32'(half_period), 32'd0);
`endif
    resetn = 1'b1;
    lock_run(1911, 4'd1, 7'b0110000, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter CONFIRM_CNT, default 4: consecutive matching half-periods required to lock a note.
REQ-002 Parameter TOL, default 16: match tolerance in clocks, applied as |P - center| <= TOL.
REQ-003 Parameter TIMEOUT, default 4095: clocks without an edge before the decoder declares silence.
REQ-004 clk  input  1  system clock.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 tone_in  input  1  asynchronous square-wave tone, piezo-style.
REQ-007 note  output  4  locked note index: 0 = none; 1..8 = C3, D, E, F, G, A, B, C4.
REQ-008 note_valid  output  1  high while a note is locked.
REQ-009 seg  output  7  seven-segment pattern for note, bit order {s1..s7}.

Function
REQ-010 tone_in SHALL pass a 2-flop synchronizer, then a 1-flop edge detector; either edge counts; an edge is flagged 3 clk after the tone_in change.
REQ-011 A 13-bit counter P SHALL clear on each flagged edge, increment otherwise, and saturate at TIMEOUT.
REQ-012 On each edge except the first after SILENT, P (clocks since the previous edge) SHALL be classified against half-period centers 1911, 1704, 1518, 1433, 1277, 1137, 1013, 957 (notes 1..8); a value outside every window is class 0 (no match).
REQ-013 FSM states SHALL be SILENT, ACQUIRE and LOCKED.
REQ-014 SILENT: the first edge starts the count, moves to ACQUIRE, and leaves the candidate empty.
REQ-015 ACQUIRE: each classified edge with class equal to the candidate and nonzero SHALL increment match_cnt.
REQ-016 ACQUIRE: any other classified edge SHALL set candidate to that class, with match_cnt = 1 if the class is nonzero, else 0.
REQ-017 ACQUIRE: when match_cnt reaches CONFIRM_CNT, the FSM SHALL go to LOCKED and load note = candidate one clk after the confirming edge.
REQ-018 LOCKED: an edge whose class equals note SHALL be held with no change.
REQ-019 LOCKED: an edge with a different class SHALL go to ACQUIRE with that class as candidate; note, note_valid and seg hold until the next lock or timeout.
REQ-020 Timeout: in any state, P reaching TIMEOUT with no edge SHALL go to SILENT and clear note, note_valid and seg on the next clk.
REQ-021 An edge in the same clk as the timeout SHALL take priority; that P is classified as class 0.
REQ-022 seg SHALL be registered with note: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 0=0000000.
REQ-023 note_valid SHALL equal (note != 0) at all times.

Reset
REQ-024 While resetn = 0 at a clk edge: state = SILENT, sync and edge flops = 0, P = 0, candidate = 0, match_cnt = 0, note = 0, note_valid = 0, seg = 0000000.
REQ-025 Reset asserted mid-lock SHALL clear all outputs on the next clk; after release, the next CONFIRM_CNT+1 edges are needed to relock.

Configuration
REQ-026 With TONE_PERIOD_OUT_EN defined, a 13-bit output half_period SHALL register P on every classified edge, reset to 0.
REQ-027 Without TONE_PERIOD_OUT_EN, the half_period port and its register SHALL be absent, with no other behaviour change.

Structure
REQ-028 Package tone_pkg SHALL hold the state enum, the eight center constants, the seg pattern table, and the counter width of 13.
REQ-029 Sub-module tone_edge_sync SHALL contain the synchronizer and edge detector; classification and FSM stay in tone_decoder.

Verification
REQ-030 Reset: hold resetn low 5 clk with tone_in toggling -> note = 0, note_valid = 0, seg = 0000000 throughout.
REQ-031 Lock: drive half-period 1911 -> note = 1, seg = 0110000 exactly 1 clk after the 5th edge; nothing earlier.
REQ-032 Change: while locked on 1, switch to half-period 957 -> note holds 1 for 3 edges, becomes 8 with seg = 1111111 after the 4th 957 edge.
REQ-033 Tolerance: half-period 1293 -> locks note 5; half-period 1294 -> never locks, note stays 0.
REQ-034 Silence: stop toggling while locked -> outputs clear 1 clk after P hits 4095; the next tone needs a fresh 5 edges.
REQ-035 Macro: with TONE_PERIOD_OUT_EN and half-period 1433 -> half_period = 1433 after each classified edge; note = 4 after lock.
